// File: rtl/usb_tx_serializer.sv
// USB transmit serializer: SYNC, PID, payload, optional CRC16, bit stuffing and
// the EOP request sequence, advancing one NRZ bit per bit_strobe.
module usb_tx_serializer #(
  parameter int unsigned STUFF_LEN = 6,
  parameter logic [7:0]  SYNC_BYTE = 8'h80
) (
  input  logic       useClk,
  input  logic       reset,
  input  logic       bit_strobe,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       tx_bit,
  output logic       tx_oe,
  output logic       tx_eop,
  output logic       busy,
  output logic       underrun
);
  localparam int unsigned   CW        = $clog2(STUFF_LEN + 1);
  localparam logic [CW-1:0] STUFF_MAX = CW'(STUFF_LEN);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC, S_EOP} state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [3:0]    r_idx, w_idx_nxt;
  logic          r_last, w_last_nxt;
  logic          r_crc_en, w_crc_en_nxt;
  logic [15:0]   r_crc, w_crc_nxt;
  logic [CW-1:0] r_stuff, w_stuff_nxt;
  logic [1:0]    r_eop_cnt, w_eop_cnt_nxt;
  logic          r_tx_bit, w_tx_bit_nxt;
  logic          r_tx_oe, w_tx_oe_nxt;
  logic          r_tx_eop, w_tx_eop_nxt;
  logic          r_underrun, w_underrun_nxt;
  logic          r_buf_full, r_buf_last;
  logic [7:0]    r_buf_data;
  logic          w_consume, w_stuff_due, w_src_bit;
  logic [15:0]   w_crc_step;

  assign w_stuff_due = (r_stuff == STUFF_MAX);
  // CRC is held reflected so the inverted remainder goes out LSB first
  assign w_src_bit   = (r_state == S_CRC) ? ~r_crc[r_idx] : r_shift[r_idx[2:0]];
  assign w_crc_step  = {1'b0, r_crc[15:1]} ^ ((r_crc[0] ^ w_src_bit) ? 16'hA001 : 16'h0000);

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_idx_nxt      = r_idx;
    w_last_nxt     = r_last;
    w_crc_en_nxt   = r_crc_en;
    w_crc_nxt      = r_crc;
    w_stuff_nxt    = r_stuff;
    w_eop_cnt_nxt  = r_eop_cnt;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_oe_nxt    = r_tx_oe;
    w_tx_eop_nxt   = r_tx_eop;
    w_underrun_nxt = 1'b0;
    w_consume      = 1'b0;
    if (bit_strobe) begin
      case (r_state)
        S_IDLE: if (r_buf_full) begin
          w_state_nxt  = S_SYNC;
          w_shift_nxt  = SYNC_BYTE;
          w_idx_nxt    = 4'd1;
          w_tx_bit_nxt = SYNC_BYTE[0];
          w_tx_oe_nxt  = 1'b1;
          w_crc_nxt    = 16'hFFFF;
          w_stuff_nxt  = CW'(SYNC_BYTE[0]);
        end
        S_SYNC, S_PID, S_DATA, S_CRC: begin
          if (w_stuff_due) begin
            w_tx_bit_nxt = 1'b0;
            w_stuff_nxt  = '0;
          end else begin
            w_tx_bit_nxt = w_src_bit;
            w_stuff_nxt  = w_src_bit ? r_stuff + 1'b1 : '0;
            w_idx_nxt    = r_idx + 4'd1;
            if (r_state == S_DATA) w_crc_nxt = w_crc_step;
            if (r_state == S_CRC) begin
              if (r_idx == 4'd15) begin
                w_state_nxt   = S_EOP;
                w_eop_cnt_nxt = '0;
              end
            end else if (r_idx == 4'd7) begin
              w_idx_nxt = '0;
              // The PID is still parked in the buffer during SYNC
              if (r_state == S_SYNC || (!r_last && r_buf_full)) begin
                w_shift_nxt = r_buf_data;
                w_last_nxt  = r_buf_last;
                w_consume   = 1'b1;
                w_state_nxt = (r_state == S_SYNC) ? S_PID : S_DATA;
                if (r_state == S_SYNC) w_crc_en_nxt = &r_buf_data[1:0];
              end else if (r_last) begin
                w_state_nxt   = r_crc_en ? S_CRC : S_EOP;
                w_eop_cnt_nxt = '0;
              end else begin
                w_underrun_nxt = 1'b1;
                w_state_nxt    = S_EOP;
                w_eop_cnt_nxt  = '0;
              end
            end
          end
        end
        S_EOP: begin
          if (w_stuff_due) begin
            w_tx_bit_nxt = 1'b0;
            w_stuff_nxt  = '0;
          end else if (r_eop_cnt != 2'd3) begin
            w_tx_bit_nxt  = 1'b0;
            w_tx_eop_nxt  = 1'b1;
            w_stuff_nxt   = '0;
            w_eop_cnt_nxt = r_eop_cnt + 2'd1;
          end else begin
            w_tx_bit_nxt = 1'b1;
            w_tx_oe_nxt  = 1'b0;
            w_tx_eop_nxt = 1'b0;
            w_state_nxt  = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge useClk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_idx      <= '0;
      r_last     <= 1'b0;
      r_crc_en   <= 1'b0;
      r_crc      <= 16'hFFFF;
      r_stuff    <= '0;
      r_eop_cnt  <= '0;
      r_tx_bit   <= 1'b1;
      r_tx_oe    <= 1'b0;
      r_tx_eop   <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_idx      <= w_idx_nxt;
      r_last     <= w_last_nxt;
      r_crc_en   <= w_crc_en_nxt;
      r_crc      <= w_crc_nxt;
      r_stuff    <= w_stuff_nxt;
      r_eop_cnt  <= w_eop_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_oe    <= w_tx_oe_nxt;
      r_tx_eop   <= w_tx_eop_nxt;
      r_underrun <= w_underrun_nxt;
    end
  end

  always_ff @(posedge useClk) begin
    if (reset) begin
      r_buf_full <= 1'b0;
      r_buf_data <= '0;
      r_buf_last <= 1'b0;
    end else if (w_consume) begin
      r_buf_full <= 1'b0;
    end else if (in_valid && !r_buf_full) begin
      r_buf_full <= 1'b1;
      r_buf_data <= in_data;
      r_buf_last <= in_last;
    end
  end

  assign in_ready = !r_buf_full;
  assign tx_bit   = r_tx_bit;
  assign tx_oe    = r_tx_oe;
  assign tx_eop   = r_tx_eop;
  assign underrun = r_underrun;
  assign busy     = (r_state != S_IDLE) || r_buf_full;
endmodule

// File: tb/tb_usb_tx_serializer.sv
// Directed bench for usb_tx_serializer: a reference model queues the expected
// line symbols per packet and a strobe monitor pops and compares them.
module tb_usb_tx_serializer;
  logic       useClk = 1'b0;
  logic       reset, bit_strobe, in_valid, in_last;
  logic [7:0] in_data;
  logic       in_ready, tx_bit, tx_oe, tx_eop, busy, underrun;

  usb_tx_serializer #(.STUFF_LEN(6), .SYNC_BYTE(8'h80)) dut (
    .useClk(useClk), .reset(reset), .bit_strobe(bit_strobe),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .tx_bit(tx_bit), .tx_oe(tx_oe), .tx_eop(tx_eop),
    .busy(busy), .underrun(underrun)
  );

  always #5 useClk = ~useClk;

  int         checks = 0, errors = 0;
  int         gap = 4, scnt = 0;
  bit         mon_en = 1'b1;
  int         oe_cnt = 0, und_cnt = 0;
  logic [1:0] exp_q[$];
  logic [1:0] gen_q[$];
  bit         gen_tail;
  logic [7:0] pkt[$];
  logic       s_str, s_rst;
  logic [1:0] s_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe generator: fixed spacing of 'gap' clocks, or random 1..7 when gap==0
  initial begin
    bit_strobe = 1'b0;
    forever begin
      @(negedge useClk);
      if (scnt <= 1) begin
        bit_strobe = 1'b1;
        scnt = (gap == 0) ? int'($urandom_range(7, 1)) : gap;
      end else begin
        bit_strobe = 1'b0;
        scnt--;
      end
    end
  end

  always @(posedge useClk) begin
    s_str = bit_strobe;
    s_rst = reset;
    #1;
    if (underrun === 1'b1) und_cnt++;
    if (s_str && !s_rst && mon_en) begin
      if (tx_oe === 1'b1) begin
        oe_cnt++;
        chk("busy_on_wire", {31'd0, busy}, 1);
        s_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
        chk("stream", {30'd0, tx_eop, tx_bit}, {30'd0, s_exp});
      end else begin
        chk("idle_line", {30'd0, tx_eop, tx_bit}, 32'd1);
      end
    end
  end

  // Reference model: raw bits, CRC16 in MSB-first form, then stuffing and EOP
  task automatic build(input logic [7:0] b[$], input bit under);
    logic [7:0]  v;
    logic        rb[$];
    logic [15:0] c;
    logic        fb;
    int          cnt;
    gen_q.delete();
    gen_tail = 1'b0;
    v = 8'h80;
    for (int i = 0; i < 8; i++) rb.push_back(v[i]);
    foreach (b[k]) begin
      v = b[k];
      for (int i = 0; i < 8; i++) rb.push_back(v[i]);
    end
    v = b[0];
    if (!under && v[1:0] == 2'b11) begin
      c = 16'hFFFF;
      for (int k = 1; k < b.size(); k++) begin
        v = b[k];
        for (int i = 0; i < 8; i++) begin
          fb = c[15] ^ v[i];
          c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
      end
      for (int i = 15; i >= 0; i--) rb.push_back(~c[i]);
    end
    cnt = 0;
    foreach (rb[k]) begin
      gen_q.push_back({1'b0, rb[k]});
      cnt = rb[k] ? cnt + 1 : 0;
      if (cnt == 6) begin
        gen_q.push_back(2'b00);
        cnt = 0;
        if (k == rb.size() - 1) gen_tail = 1'b1;
      end
    end
    repeat (3) gen_q.push_back(2'b10);
  endtask

  task automatic put_byte(input logic [7:0] d, input logic l);
    bit done = 1'b0;
    @(negedge useClk);
    in_data = d; in_valid = 1'b1; in_last = l;
    for (int t = 0; t < 4000 && !done; t++) begin
      done = in_ready;
      @(posedge useClk);
      if (!done) @(negedge useClk);
    end
    #1;
    if (done) chk("in_ready_full", {31'd0, in_ready}, 0);
    else      chk("accept_timeout", {31'd0, in_ready}, 1);
  endtask

  task automatic send(input logic [7:0] b[$], input bit under);
    build(b, under);
    foreach (gen_q[k]) exp_q.push_back(gen_q[k]);
    for (int k = 0; k < b.size(); k++) put_byte(b[k], !under && (k == b.size() - 1));
    @(negedge useClk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    do begin
      @(negedge useClk);
      t++;
    end while (busy !== 1'b0 && t < 20000);
    chk({tag, "_done"}, {31'd0, busy}, 0);
    chk({tag, "_drain"}, exp_q.size(), 0);
    chk({tag, "_oe_low"}, {31'd0, tx_oe}, 0);
  endtask

  task automatic wait_strobes(input int n);
    int t = 0;
    while (t < n) begin
      @(posedge useClk);
      if (bit_strobe) t++;
    end
  endtask

  initial begin
    bit found;
    logic [7:0] fi, fj;
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge useClk);
    #1;
    chk("rst_tx_bit", {31'd0, tx_bit}, 1);
    chk("rst_tx_oe", {31'd0, tx_oe}, 0);
    chk("rst_tx_eop", {31'd0, tx_eop}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_underrun", {31'd0, underrun}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    @(negedge useClk) reset = 1'b0;

    // ACK handshake packet
    oe_cnt = 0; und_cnt = 0;
    pkt = {8'hD2};
    send(pkt, 1'b0);
    chk("ack_busy", {31'd0, busy}, 1);
    wait_idle("ack");
    chk("ack_oe_strobes", oe_cnt, 19);
    chk("ack_idle_bit", {31'd0, tx_bit}, 1);

    // Zero-length DATA1: CRC only
    oe_cnt = 0;
    pkt = {8'h4B};
    send(pkt, 1'b0);
    wait_idle("zlp");
    chk("zlp_oe_strobes", oe_cnt, 35);

    // Stuffing through an all-ones payload
    oe_cnt = 0;
    pkt = {8'hC3, 8'hFF, 8'hFF};
    send(pkt, 1'b0);
    wait_idle("stuff");
    chk("stuff_oe_strobes", oe_cnt, gen_q.size());

    // Payload whose CRC tail needs a trailing stuff bit before EOP
    found = 1'b0; fi = 8'h00; fj = 8'h00;
    for (int i = 0; i < 256 && !found; i++)
      for (int j = 0; j < 256 && !found; j++) begin
        pkt = {8'hC3, 8'(i), 8'(j)};
        build(pkt, 1'b0);
        if (gen_tail) begin found = 1'b1; fi = 8'(i); fj = 8'(j); end
      end
    if (found) begin
      oe_cnt = 0;
      pkt = {8'hC3, fi, fj};
      send(pkt, 1'b0);
      wait_idle("tail_stuff");
      chk("tail_oe_strobes", oe_cnt, gen_q.size());
    end

    // Back-to-back payload, strobe every clock, then irregular spacing
    pkt = {8'h4B, 8'h00, 8'h01, 8'h02, 8'h03, 8'hA5, 8'h7E, 8'hFF, 8'h3C};
    gap = 1; oe_cnt = 0; und_cnt = 0;
    send(pkt, 1'b0);
    wait_idle("b2b");
    chk("b2b_underrun", und_cnt, 0);
    chk("b2b_oe_strobes", oe_cnt, gen_q.size());
    gap = 0; oe_cnt = 0;
    send(pkt, 1'b0);
    wait_idle("irregular");
    chk("irr_underrun", und_cnt, 0);
    chk("irr_oe_strobes", oe_cnt, gen_q.size());

    // Underrun after one payload byte
    gap = 3; und_cnt = 0; oe_cnt = 0;
    pkt = {8'hC3, 8'hA5};
    send(pkt, 1'b1);
    wait_idle("underrun");
    chk("underrun_pulses", und_cnt, 1);
    chk("underrun_oe_strobes", oe_cnt, gen_q.size());

    // Reset while in DATA, then a clean ACK
    mon_en = 1'b0; gap = 2;
    put_byte(8'hC3, 1'b0);
    put_byte(8'hFF, 1'b0);
    put_byte(8'hFF, 1'b0);
    wait_strobes(3);
    @(negedge useClk);
    in_valid = 1'b0; reset = 1'b1;
    @(posedge useClk);
    #1;
    chk("midrst_tx_oe", {31'd0, tx_oe}, 0);
    chk("midrst_tx_eop", {31'd0, tx_eop}, 0);
    chk("midrst_in_ready", {31'd0, in_ready}, 1);
    chk("midrst_busy", {31'd0, busy}, 0);
    @(negedge useClk) reset = 1'b0;
    exp_q.delete();
    oe_cnt = 0; mon_en = 1'b1;
    pkt = {8'hD2};
    send(pkt, 1'b0);
    wait_idle("post_rst_ack");
    chk("post_rst_oe_strobes", oe_cnt, 19);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/usb_tx_serializer.md
Name: usb_tx_serializer

Overview:
Transmit-side packet serializer that feeds the NRZI line encoder. It accepts packet bytes over a valid/ready handshake and emits one NRZ bit per bit strobe. Its output stream is SYNC, PID, payload, then CRC16 (data PIDs only). It inserts USB bit-stuff zeros and finishes with the EOP request sequence. Its outputs connect directly to the encoder's bit-strobe, data, output-enable and EOP inputs.

Parameters:
STUFF_LEN, 6, run of consecutive 1 bits after which a stuffed 0 is inserted
SYNC_BYTE, 8'h80, sync pattern, sent LSB first

Ports:
useClk  in  1  system clock
reset  in  1  synchronous, active-high reset
bit_strobe  in  1  one-cycle pulse per USB bit time (12 MHz rate); all state advances only on strobe cycles
in_data  in  8  packet byte; first byte of a packet is the PID
in_valid  in  1  in_data valid
in_last  in  1  marks final byte of packet, qualified with in_valid
in_ready  out  1  byte accepted when in_valid && in_ready
tx_bit  out  1  NRZ bit to encoder; 1 = no transition, 0 = transition
tx_oe  out  1  packet on wire (SYNC through EOP)
tx_eop  out  1  EOP request to encoder, high for exactly 3 strobes
busy  out  1  high from packet start until tx_oe falls
underrun  out  1  one-cycle pulse on payload starvation

Behaviour:
- Clock and reset: one clock, useClk. Reset is synchronous and active-high. On reset: state IDLE; holding buffer empty; tx_bit=1, tx_oe=0, tx_eop=0, busy=0, underrun=0, in_ready=1; CRC=16'hFFFF; stuff counter=0.
- Reset asserted mid-packet takes priority on that edge and abandons the packet with no EOP.
- Input buffering: one-byte holding buffer. in_ready = buffer empty. A byte can be accepted on any cycle, strobe or not.
- Outputs change only on cycles where bit_strobe=1; they hold their values otherwise.
- States: IDLE, SYNC, PID, DATA, CRC, EOP.
- IDLE: busy=1 as soon as the buffer holds a byte. On the next strobe: go to SYNC, tx_oe=1, emit SYNC bit 0.
- Bit order: every byte goes out LSB first. SYNC is 0,0,0,0,0,0,0,1.
- SYNC -> PID: the PID byte moves into the shift register. CRC is appended iff PID[1:0]==2'b11 (DATA0/1/2, MDATA).
- After the 8th bit of a byte:
  - If in_last was set on that byte, go to CRC when CRC applies, otherwise to EOP.
  - Else, if the buffer holds a byte, go to DATA with that byte (no bubble).
  - Else (buffer empty): underrun. Pulse underrun, go straight to EOP, no CRC.
- CRC16:
  - Polynomial x^16+x^15+x^2+1, seed 16'hFFFF.
  - Updated per emitted payload data bit; PID, SYNC and stuffed bits excluded.
  - Sent inverted, LSB first, 16 bits.
- Bit stuffing:
  - The counter counts consecutive emitted 1s from the first SYNC bit through the last CRC/PID/data bit. Any emitted 0 clears it.
  - When the count reaches STUFF_LEN, the next strobe emits a stuffed 0 and clears the counter. The shift register, bit index and CRC do not advance.
  - A stuff due after the final bit is emitted before EOP.
- EOP:
  - tx_eop=1 and tx_oe=1 for 3 consecutive strobes; the tx_bit value is don't-care, driven 0.
  - On the following strobe: tx_oe=0, tx_eop=0, busy=0, tx_bit=1; go to IDLE.
  - A new packet can start on the strobe after that.
- in_valid with in_last on the PID byte of a data PID produces a zero-length packet: CRC only.

Test Plan:
- ACK: single byte 8'hD2 with in_last, strobe every 4 clocks. Required stream: tx_bit 0000000 1, then PID bits 0,1,0,0,1,0,1,1, then 3 strobes with tx_eop=1. tx_oe high for exactly 19 strobes; no CRC; then idle with tx_bit=1.
- Zero-length DATA1: 8'h4B with in_last. Required: SYNC, PID, then 16 CRC bits all 0, then EOP. No stuffing occurs; total tx_oe = 35 strobes.
- Stuffing: DATA0 8'hC3 with payload 8'hFF, 8'hFF. A 0 is inserted after every 6 consecutive 1s, with no interruption of the payload bit order. CRC matches the reference model over 8'hFF,8'hFF only. Check the stuff inserted after the last CRC bit when the CRC tail is all 1s.
- Back-to-back bytes: 8 payload bytes presented with in_valid held. No gap strobes between bytes and in_ready deasserts while the buffer is full. Irregular bit_strobe spacing (1–7 clocks) yields an identical stream.
- Underrun: DATA0 with one payload byte, in_valid dropped before the second. underrun pulses once; EOP follows immediately with no CRC; busy falls after EOP.
- Reset mid-packet: reset during DATA. The next cycle shows tx_oe=0, tx_eop=0, in_ready=1, busy=0. A subsequent ACK packet is sent correctly with the stuff counter cleared.
